// File: rtl/rpi_audio_pkg.sv
// ============================================================================
// Module   : rpi_audio_pkg
// Purpose  : Shared types and default constants for the Raspberry Pi audio
//            capture path (sample FIFO, interrupt request FSM).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rpi_audio_pkg;

   // Default geometry of the capture FIFO
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_DEPTH   = 64;

   // Default interrupt watermarks and release hold-off (clk_in cycles)
   localparam int DEF_HIGH_WM = 32;
   localparam int DEF_LOW_WM  = 8;
   localparam int DEF_HOLDOFF = 1024;

   // Interrupt request FSM states
   typedef enum logic [1:0] {
      IRQ_IDLE   = 2'd0,
      IRQ_ASSERT = 2'd1,
      IRQ_HOLD   = 2'd2
   } irq_state_e;

endpackage : rpi_audio_pkg

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Brings an asynchronous GPIO level into clk_in and emits a
//            one-cycle registered pulse on each rising edge.
// Ports    : clk_in     - destination clock
//            reset_n    - asynchronous active-low reset
//            async_in   - asynchronous input level
//            rise_pulse - one-cycle pulse, two edges after the input is
//                         first sampled
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_edge_detect (
   input  logic clk_in,
   input  logic reset_n,
   input  logic async_in,
   output logic rise_pulse
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       prev_q,  prev_d;
   logic       armed_q, armed_d;
   logic       pulse_q, pulse_d;
   logic [1:0] fill_q,  fill_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      // fill_q[1] marks that sync2_q now holds a genuinely sampled value
      // rather than its reset value.
      fill_d  = {fill_q[0], 1'b1};
      // Only arm once a real low level has been seen after reset, so an input
      // that is already high when reset releases does not look like an edge.
      armed_d = armed_q | (fill_q[1] & ~sync2_q);
      pulse_d = armed_q & sync2_q & ~prev_q;
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         pulse_q <= 1'b0;
         fill_q  <= 2'b00;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         armed_q <= armed_d;
         pulse_q <= pulse_d;
         fill_q  <= fill_d;
      end
   end

   assign rise_pulse = pulse_q;

endmodule : sync_edge_detect

`default_nettype wire

// File: rtl/rpi_sample_fifo_irq.sv
// ============================================================================
// Module   : rpi_sample_fifo_irq
// Purpose  : Circular sample FIFO between the I2S receiver and the Pi, with
//            watermark/hold-off interrupt request and asynchronous Pi reads.
// Ports    : clk_in, reset_n          - 50 MHz clock, async active-low reset
//            sample_in, sample_valid  - push interface from I2S receiver
//            rpi_rd                   - async Pi read strobe (rising = pop)
//            clear_flags              - clears overflow/underflow
//            rd_data, rd_valid        - last popped word, update pulse
//            interrupt_enable         - registered interrupt request
//            level                    - current fill count
//            overflow, underflow      - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rpi_sample_fifo_irq
   import rpi_audio_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int HIGH_WM = DEF_HIGH_WM,
   parameter int LOW_WM  = DEF_LOW_WM,
   parameter int HOLDOFF = DEF_HOLDOFF
) (
   input  logic                       clk_in,
   input  logic                       reset_n,
   input  logic [DATA_W-1:0]          sample_in,
   input  logic                       sample_valid,
   input  logic                       rpi_rd,
   input  logic                       clear_flags,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   output logic                       interrupt_enable,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(HOLDOFF + 1);

   localparam logic [PW-1:0] HIGH_L    = PW'(HIGH_WM);
   localparam logic [PW-1:0] LOW_L     = PW'(LOW_WM);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

   // ------------------------------------------------------------------
   // Pi read strobe synchronizer
   // ------------------------------------------------------------------
   logic rd_rise;

   sync_edge_detect u_rd_sync (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .async_in   (rpi_rd),
      .rise_pulse (rd_rise)
   );

   // ------------------------------------------------------------------
   // FIFO datapath
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              full;
   logic              empty;
   logic              do_pop;
   logic              do_push;
   logic [PW-1:0]     level_w;

   always_comb begin
      // Extra pointer MSB distinguishes full from empty when indices match
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty   = (wr_ptr_q == rd_ptr_q);
      level_w = wr_ptr_q - rd_ptr_q;

      // A pop on a full FIFO frees the slot for a same-cycle push; an empty
      // FIFO never bypasses the incoming word to the reader.
      do_pop  = rd_rise & ~empty;
      do_push = sample_valid & (~full | do_pop);

      wr_ptr_d    = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      rd_data_d   = do_pop  ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
      rd_valid_d  = do_pop;

      // A new error event takes priority over a simultaneous clear
      overflow_d  = (overflow_q  & ~clear_flags) | (sample_valid & ~do_push);
      underflow_d = (underflow_q & ~clear_flags) | (rd_rise & empty);
   end

   // Storage needs no reset: the pointers define which entries are valid
   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= sample_in;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // ------------------------------------------------------------------
   // Interrupt request FSM with watermark hysteresis and hold-off
   // ------------------------------------------------------------------
   irq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ie_q, ie_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IRQ_IDLE: begin
            if (level_w >= HIGH_L) begin
               state_d = IRQ_ASSERT;
            end
         end
         IRQ_ASSERT: begin
            if (level_w <= LOW_L) begin
               state_d = IRQ_HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         IRQ_HOLD: begin
            // Fill level is deliberately ignored until the hold-off expires
            if (cnt_q == '0) begin
               state_d = IRQ_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IRQ_IDLE;
         end
      endcase
      // Output decoded from the next state and registered, so it switches on
      // the same edge as the state register without decode glitches.
      ie_d = (state_d == IRQ_ASSERT);
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IRQ_IDLE;
         cnt_q   <= '0;
         ie_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ie_q    <= ie_d;
      end
   end

   assign rd_data          = rd_data_q;
   assign rd_valid         = rd_valid_q;
   assign interrupt_enable = ie_q;
   assign level            = level_w;
   assign overflow         = overflow_q;
   assign underflow        = underflow_q;

endmodule : rpi_sample_fifo_irq

`default_nettype wire

// File: tb/tb_rpi_sample_fifo_irq.sv
// ============================================================================
// Module   : tb_rpi_sample_fifo_irq
// Purpose  : Self-checking bench for rpi_sample_fifo_irq against a queue-based
//            reference model of the FIFO, flags and interrupt hysteresis.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rpi_sample_fifo_irq;

   localparam int DATA_W  = 32;
   localparam int DEPTH   = 64;
   localparam int HIGH_WM = 32;
   localparam int LOW_WM  = 8;
   localparam int HOLDOFF = 1024;

   logic              clk_in = 1'b0;
   logic              reset_n;
   logic [DATA_W-1:0] sample_in;
   logic              sample_valid;
   logic              rpi_rd;
   logic              clear_flags;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              interrupt_enable;
   logic [6:0]        level;
   logic              overflow;
   logic              underflow;

   always #5 clk_in = ~clk_in;

   rpi_sample_fifo_irq #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .HIGH_WM (HIGH_WM),
      .LOW_WM  (LOW_WM),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clk_in           (clk_in),
      .reset_n          (reset_n),
      .sample_in        (sample_in),
      .sample_valid     (sample_valid),
      .rpi_rd           (rpi_rd),
      .clear_flags      (clear_flags),
      .rd_data          (rd_data),
      .rd_valid         (rd_valid),
      .interrupt_enable (interrupt_enable),
      .level            (level),
      .overflow         (overflow),
      .underflow        (underflow)
   );

   // ---------------- reference model state ----------------
   logic [31:0] mq[$];
   logic        exp_ovf, exp_unf, exp_ie, exp_rdv;
   logic [31:0] exp_rdd;
   int          quiet;          // cycles the request must still stay low
   logic [3:0]  h;              // rpi_rd driven for the previous 4 edges
   int          low_run, last_low_run;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_ovf = 1'b0; exp_unf = 1'b0; exp_ie = 1'b0; exp_rdv = 1'b0;
      exp_rdd = '0;   quiet = 0;
      // Treat the strobe as already high so a level held across reset
      // release never counts as a rising edge.
      h = 4'hF;
      low_run = 0;
   endtask

   // One clock cycle: drive inputs, advance the model, compare all outputs.
   task automatic step(input logic sv, input logic [31:0] d, input logic rd, input logic clr);
      int   l;
      logic pop_req, pop_ok, push_ok;
      sample_valid = sv; sample_in = d; rpi_rd = rd; clear_flags = clr;
      l       = mq.size();
      // A strobe edge presented three edges ago becomes a pop at this edge
      pop_req = h[2] & ~h[3];
      pop_ok  = pop_req && (l > 0);
      push_ok = sv && ((l < DEPTH) || pop_ok);
      if (exp_ie) begin
         if (l <= LOW_WM) begin
            exp_ie = 1'b0;
            quiet  = HOLDOFF;
         end
      end else if (quiet > 0) begin
         quiet--;
      end else if (l >= HIGH_WM) begin
         exp_ie = 1'b1;
      end
      @(posedge clk_in); #1;
      h = {h[2:0], rd};
      exp_rdv = pop_ok;
      if (pop_ok)  exp_rdd = mq.pop_front();
      if (push_ok) mq.push_back(d);
      exp_ovf = (exp_ovf & ~clr) | (sv & ~push_ok);
      exp_unf = (exp_unf & ~clr) | (pop_req & ~pop_ok);
      chk("level",     32'(level),            32'(mq.size()));
      chk("rd_valid",  32'(rd_valid),         32'(exp_rdv));
      chk("rd_data",   rd_data,               exp_rdd);
      chk("overflow",  32'(overflow),         32'(exp_ovf));
      chk("underflow", 32'(underflow),        32'(exp_unf));
      chk("irq",       32'(interrupt_enable), 32'(exp_ie));
      if (interrupt_enable) begin
         if (low_run > 0) last_low_run = low_run;
         low_run = 0;
      end else begin
         low_run++;
      end
   endtask

   task automatic rd_pulse(input int hi, input int lo, input bit rnd_push);
      for (int i = 0; i < hi + lo; i++) begin
         step(rnd_push ? (($urandom % 4) == 0) : 1'b0, $urandom, (i < hi), 1'b0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"}, 32'(level),            0);
      chk({tag, "_ie"},    32'(interrupt_enable), 0);
      chk({tag, "_rdv"},   32'(rd_valid),         0);
      chk({tag, "_rdd"},   rd_data,               0);
      chk({tag, "_ovf"},   32'(overflow),         0);
      chk({tag, "_unf"},   32'(underflow),        0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  found;
      reset_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
      rpi_rd = 1'b0;  clear_flags = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;
      repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);

      // 32 pushes reach the high watermark; request follows one cycle later
      for (int i = 1; i <= 32; i++) step(1'b1, {16'(i), 16'(i)}, 1'b0, 1'b0);
      chk("level_after_32",  32'(level), 32);
      chk("ie_at_32nd_push", 32'(interrupt_enable), 0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("ie_after_32",     32'(interrupt_enable), 1);

      // 24 reads bring the level to the low watermark
      for (int i = 0; i < 24; i++) rd_pulse(4, 4, 1'b0);
      chk("last_pop_data", rd_data, 32'h0018_0018);
      chk("level_after_24_pops", 32'(level), 8);
      chk("ie_released", 32'(interrupt_enable), 0);

      // Refill to 40 inside the hold-off; request must stay low throughout
      for (int i = 0; i < 32; i++) step(1'b1, 32'h5500_0000 + i, 1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0);
         found = interrupt_enable;
      end
      chk("ie_reassert_seen", 32'(found), 1);
      // HOLDOFF hold cycles plus the IDLE cycle that re-evaluates the level
      chk("holdoff_low_cycles", 32'(last_low_run), HOLDOFF + 1);

      // Drain completely
      n = 0;
      while (mq.size() > 0 && n < 100) begin
         rd_pulse(4, 4, 1'b0);
         n++;
      end
      chk("drained", 32'(level), 0);

      // Read while empty
      rd_pulse(4, 4, 1'b0);
      chk("underflow_set", 32'(underflow), 1);
      chk("rd_data_held",  rd_data, 32'h5500_001F);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("underflow_cleared", 32'(underflow), 0);

      // 65 pushes into an empty FIFO
      for (int i = 0; i < 65; i++) step(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0);
      chk("level_full",   32'(level), 64);
      chk("overflow_set", 32'(overflow), 1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("overflow_cleared", 32'(overflow), 0);

      // Full FIFO: push lands on the same edge as a pop
      for (int i = 0; i < 4; i++) step((i == 3), 32'hBEEF_0001, 1'b1, 1'b0);
      chk("level_full_pushpop", 32'(level), 64);
      chk("no_ovf_pushpop",     32'(overflow), 0);
      chk("popped_first",       rd_data, 32'hA000_0000);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

      // Randomised mixed traffic
      for (int i = 0; i < 40; i++) begin
         rd_pulse(3 + int'($urandom % 3), 3 + int'($urandom % 3), 1'b1);
         if (($urandom % 8) == 0) step(1'b0, 32'h0, 1'b0, 1'b1);
      end

      // Reset while requesting and with the read strobe high
      found = interrupt_enable;
      for (int i = 0; i < 3000 && !found; i++) begin
         step(1'b1, $urandom, 1'b0, 1'b0);
         found = interrupt_enable;
      end
      chk("ie_before_reset", 32'(found), 1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      model_reset();
      @(posedge clk_in); @(posedge clk_in);
      #1;
      reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0);
         if (rd_valid) n++;
      end
      chk("no_pop_after_reset", 32'(n), 0);
      chk("no_unf_after_reset", 32'(underflow), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rpi_sample_fifo_irq

`default_nettype wire
